// File: rtl/fp_norm_sequencer_pkg.sv
// +--------------------------------------------------------------------------+
// | fp_norm_sequencer_pkg : shared widths, FSM encoding and flag bit indices |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package fp_norm_sequencer_pkg;

  localparam int SIG_W_DEF = 24;
  localparam int EXP_W_DEF = 8;
  localparam int SHAMT_W   = 5;

  localparam int FLAG_ZERO   = 0;
  localparam int FLAG_DENORM = 1;
  localparam int FLAG_OVF    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } norm_state_t;

endpackage

`default_nettype wire

// File: rtl/fp_norm_sequencer_step.sv
// +--------------------------------------------------------------------------+
// | fp_norm_sequencer_step : one combinational normalization step            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module fp_norm_sequencer_step
  import fp_norm_sequencer_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF,
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic [SIG_W-1:0]   sig_i,
  input  logic [EXP_W:0]     exp_i,
  input  logic               carry_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [SIG_W-1:0]   sig_o,
  output logic [EXP_W:0]     exp_o,
  output logic [SHAMT_W-1:0] shamt_o,
  output logic [2:0]         flags_o,
  output logic               done_o
);

  localparam logic [EXP_W:0] c_EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] c_EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

  logic [EXP_W:0] exp_inc;

  always_comb begin
    sig_o   = sig_i;
    exp_o   = exp_i;
    shamt_o = shamt_i;
    flags_o = '0;
    done_o  = 1'b1;
    exp_inc = exp_i + c_EXP_ONE;
    if (carry_i) begin
      sig_o = {1'b1, sig_i[SIG_W-1:1]};
      exp_o = exp_inc;
      if (exp_inc == c_EXP_MAX) begin
        sig_o              = '0;
        flags_o[FLAG_OVF]  = 1'b1;
      end
    end else if (sig_i == '0) begin
      exp_o              = '0;
      flags_o[FLAG_ZERO] = 1'b1;
    end else if (exp_i == '0) begin
      // A denormal operand may have summed into the normal range.
      if (sig_i[SIG_W-1]) exp_o = c_EXP_ONE;
      else                flags_o[FLAG_DENORM] = 1'b1;
    end else if (!sig_i[SIG_W-1]) begin
      if (exp_i == c_EXP_ONE) begin
        exp_o                = '0;
        flags_o[FLAG_DENORM] = 1'b1;
      end else begin
        sig_o   = sig_i << 1;
        exp_o   = exp_i - c_EXP_ONE;
        shamt_o = shamt_i + {{(SHAMT_W-1){1'b0}}, 1'b1};
        done_o  = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_norm_sequencer.sv
// +--------------------------------------------------------------------------+
// | fp_norm_sequencer : multi-cycle FP add/sub normalizer, valid/ready I/O   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module fp_norm_sequencer
  import fp_norm_sequencer_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF,
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [SIG_W-1:0]   in_sig_i,
  input  logic               in_carry_i,
  input  logic [EXP_W-1:0]   in_exp_i,
  input  logic               in_sign_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [SIG_W-1:0]   out_sig_o,
  output logic [EXP_W-1:0]   out_exp_o,
  output logic               out_sign_o,
  output logic [SHAMT_W-1:0] out_shamt_o,
  output logic [2:0]         out_flags_o
);

  norm_state_t        state_q, state_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [EXP_W:0]     exp_q, exp_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [2:0]         flags_q, flags_d;
  logic               carry_q;
  logic               sign_q;
  logic               step_done;
  logic               accept;

  fp_norm_sequencer_step #(
    .SIG_W (SIG_W),
    .EXP_W (EXP_W)
  ) u_step (
    .sig_i   (sig_q),
    .exp_i   (exp_q),
    .carry_i (carry_q),
    .shamt_i (shamt_q),
    .sig_o   (sig_d),
    .exp_o   (exp_d),
    .shamt_o (shamt_d),
    .flags_o (flags_d),
    .done_o  (step_done)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid_i) state_d = ST_NORM;
      ST_NORM: if (step_done) state_d = ST_DONE;
      ST_DONE: if (out_ready_i) state_d = in_valid_i ? ST_NORM : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready_i);
    out_valid_o = (state_q == ST_DONE);
  end

  assign accept = in_valid_i && in_ready_o;

  // Working registers double as the output registers; they only move in NORM or on accept.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sig_q   <= '0;
      exp_q   <= '0;
      shamt_q <= '0;
      flags_q <= '0;
      carry_q <= 1'b0;
      sign_q  <= 1'b0;
    end else if (accept) begin
      sig_q   <= in_sig_i;
      exp_q   <= {1'b0, in_exp_i};
      shamt_q <= '0;
      flags_q <= '0;
      carry_q <= in_carry_i;
      sign_q  <= in_sign_i;
    end else if (state_q == ST_NORM) begin
      sig_q   <= sig_d;
      exp_q   <= exp_d;
      shamt_q <= shamt_d;
      flags_q <= flags_d;
      carry_q <= 1'b0;
    end
  end

  assign out_sig_o   = sig_q;
  assign out_exp_o   = exp_q[EXP_W-1:0];
  assign out_sign_o  = sign_q;
  assign out_shamt_o = shamt_q;
  assign out_flags_o = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_norm_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_fp_norm_sequencer : directed vectors with queue-based scoreboard      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fp_norm_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_sig = '0;
  logic        in_carry = 1'b0;
  logic [7:0]  in_exp = '0;
  logic        in_sign = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_sig;
  logic [7:0]  out_exp;
  logic        out_sign;
  logic [4:0]  out_shamt;
  logic [2:0]  out_flags;

  fp_norm_sequencer dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_sig_i    (in_sig),
    .in_carry_i  (in_carry),
    .in_exp_i    (in_exp),
    .in_sign_i   (in_sign),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sig_o   (out_sig),
    .out_exp_o   (out_exp),
    .out_sign_o  (out_sign),
    .out_shamt_o (out_shamt),
    .out_flags_o (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] sig;
    logic        carry;
    logic [7:0]  exp;
    logic        sign;
    logic [23:0] esig;
    logic [7:0]  eexp;
    logic [4:0]  eshamt;
    logic [2:0]  eflags;
  } vec_t;

  typedef struct {
    logic [23:0] sig;
    logic [7:0]  exp;
    logic        sign;
    logic [4:0]  shamt;
    logic [2:0]  flags;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: latency on first out_valid, field compare on each handshake.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (sb.size() == 0 || acc_q.size() == 0)
          check("unexpected_out_valid", 32'd1, 32'd0);
        else
          check("latency", 32'(cyc - acc_q.pop_front()), 32'(2 + int'(sb[0].shamt)));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_sig",   32'(out_sig),   32'(e.sig));
          check("out_exp",   32'(out_exp),   32'(e.exp));
          check("out_sign",  32'(out_sign),  32'(e.sign));
          check("out_shamt", 32'(out_shamt), 32'(e.shamt));
          check("out_flags", 32'(out_flags), 32'(e.flags));
        end
        seen = 1'b0;
      end
      if (in_valid && in_ready) acc_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input vec_t v);
    exp_t e;
    int   n;
    e.sig = v.esig; e.exp = v.eexp; e.sign = v.sign; e.shamt = v.eshamt; e.flags = v.eflags;
    sb.push_back(e);
    in_valid = 1'b1; in_sig = v.sig; in_carry = v.carry; in_exp = v.exp; in_sign = v.sign;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("in_ready_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  vec_t tbl[12];
  vec_t v;

  initial begin
    //          sig        c     exp    s     esig       eexp   sh     flags
    tbl[0]  = '{24'h800000, 1'b0, 8'h80, 1'b0, 24'h800000, 8'h80, 5'd0,  3'b000};
    tbl[1]  = '{24'hC00000, 1'b1, 8'h7F, 1'b1, 24'hE00000, 8'h80, 5'd0,  3'b000};
    tbl[2]  = '{24'h000100, 1'b0, 8'h80, 1'b0, 24'h800000, 8'h71, 5'd15, 3'b000};
    tbl[3]  = '{24'h000100, 1'b0, 8'h03, 1'b1, 24'h000400, 8'h00, 5'd2,  3'b010};
    tbl[4]  = '{24'h400000, 1'b1, 8'hFE, 1'b0, 24'h000000, 8'hFF, 5'd0,  3'b100};
    tbl[5]  = '{24'h000000, 1'b0, 8'h05, 1'b1, 24'h000000, 8'h00, 5'd0,  3'b001};
    tbl[6]  = '{24'h800000, 1'b0, 8'h00, 1'b0, 24'h800000, 8'h01, 5'd0,  3'b000};
    tbl[7]  = '{24'h000001, 1'b0, 8'h80, 1'b0, 24'h800000, 8'h69, 5'd23, 3'b000};
    tbl[8]  = '{24'h000001, 1'b0, 8'h00, 1'b1, 24'h000001, 8'h00, 5'd0,  3'b010};
    tbl[9]  = '{24'h400000, 1'b0, 8'h01, 1'b0, 24'h400000, 8'h00, 5'd0,  3'b010};
    tbl[10] = '{24'h000000, 1'b1, 8'h10, 1'b1, 24'h800000, 8'h11, 5'd0,  3'b000};
    tbl[11] = '{24'h100000, 1'b0, 8'h02, 1'b0, 24'h200000, 8'h00, 5'd1,  3'b010};

    repeat (3) tick();
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sig",   32'(out_sig),   32'd0);
    check("rst_out_exp",   32'(out_exp),   32'd0);
    check("rst_out_shamt", 32'(out_shamt), 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;

    // Back-to-back stream: each operand is accepted on the previous handshake edge.
    foreach (tbl[i]) send(tbl[i]);
    drain();

    // Downstream stall: outputs must hold in DONE, then a same-cycle handoff.
    out_ready = 1'b0;
    v = '{24'h800000, 1'b0, 8'h80, 1'b1, 24'h800000, 8'h80, 5'd0, 3'b000};
    send(v);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) check("stall_valid_timeout", 32'd0, 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_sig",   32'(out_sig),   32'h800000);
      check("stall_exp",   32'(out_exp),   32'h80);
      check("stall_sign",  32'(out_sign),  32'd1);
      check("stall_ready", 32'(in_ready),  32'd0);
      @(negedge clk);
    end
    tick();
    out_ready = 1'b1;
    send(tbl[3]);
    drain();

    // Reset while normalizing: in-flight operand is discarded.
    send(tbl[2]);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    sb.delete();
    acc_q.delete();
    seen = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("midrst_no_output", 32'(out_valid), 32'd0);
    end
    tick();
    send(tbl[1]);
    drain();

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
